aes_key_expand_ctrl: RTL and testbench

Sequencer that drives the single-round `KeySchedule` datapath through all ten AES-128 key-expansion rounds. It supplies the round constant, feeds each round key back as the next round's input, and captures every round key into an 11-entry store. Round keys are readable by index. The block sits between the top-level AES controller (start/done) and the cipher rounds, which read round keys via the read port.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_rk_store.sv | 35 +++
 rtl/aes_key_expand_ctrl.sv | 159 +++++++++++++++
 tb/tb_aes_key_expand_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES key-expansion sequencer.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StGap,
    StErr
  } kexp_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] aes_xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: one synchronous write port, async clear, combinational read.
module aes_rk_store
  import aes_pkg::*;
#(
  parameter int unsigned NUM   = AES_NR + 1,
  parameter int unsigned KEY_W = AES_KEY_W,
  parameter int unsigned IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [KEY_W-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [KEY_W-1:0] o_rdata
);

  logic [KEY_W-1:0] r_mem [NUM];

  // Capture a round key; writes to nonexistent entries are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM); i++) r_mem[i] <= '0;
    end else if (i_we && (32'(i_widx) < NUM)) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  // Out-of-range indices read back as zero.
  always_comb begin
    o_rdata = '0;
    if (32'(i_ridx) < NUM) o_rdata = r_mem[i_ridx];
  end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// Sequences the single-round KeySchedule through all AES-128 expansion rounds
// and records every round key in a readable store.
module aes_key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR      = AES_NR,
  parameter int unsigned KEY_W   = AES_KEY_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] cipher_key_i,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rk_valid,
  output logic [3:0]       rk_idx,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             ks_en,
  output logic [7:0]       ks_rcon,
  output logic [KEY_W-1:0] ks_key_o,
  input  logic             ks_flag_i,
  input  logic [KEY_W-1:0] ks_key_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LAST  = 4'(NR);

  kexp_state_t      r_state;
  logic [3:0]       r_round;
  logic [7:0]       r_rcon;
  logic [7:0]       r_ks_rcon;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_key;
  logic             r_ks_en;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_rk_valid;
  logic [3:0]       r_rk_idx;

  logic             w_start_ok;
  logic             w_capture;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic             w_we;
  logic [3:0]       w_widx;
  logic [KEY_W-1:0] w_wdata;

  assign w_start_ok = start && ((r_state == StIdle) || (r_state == StErr));
  assign w_capture  = (r_state == StWait) && ks_flag_i;
  assign w_last     = (r_round == LAST);
  assign w_cnt_inc  = r_cnt + 1'b1;
  // A flag arriving in the timeout cycle takes priority.
  assign w_timeout  = (r_state == StWait) && !ks_flag_i && (w_cnt_inc == CNT_W'(TIMEOUT));

  // Store write: entry 0 on accepted start, entry `round` on each captured key.
  always_comb begin
    w_we    = w_start_ok || w_capture;
    w_widx  = w_start_ok ? 4'd0 : r_round;
    w_wdata = w_start_ok ? cipher_key_i : ks_key_i;
  end

  aes_rk_store #(
    .NUM  (NR + 1),
    .KEY_W(KEY_W),
    .IDX_W(4)
  ) u_store (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_we   (w_we),
    .i_widx (w_widx),
    .i_wdata(w_wdata),
    .i_ridx (rd_idx),
    .o_rdata(rd_key)
  );

  // Control FSM with round counter, RCON, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_round    <= '0;
      r_rcon     <= RCON_INIT;
      r_ks_rcon  <= '0;
      r_cnt      <= '0;
      r_key      <= '0;
      r_ks_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_idx   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rk_valid <= 1'b0;
      unique case (r_state)
        StIdle, StErr: begin
          r_busy <= 1'b0;
          if (start) begin
            r_key     <= cipher_key_i;
            r_round   <= 4'd1;
            r_rcon    <= RCON_INIT;
            r_ks_rcon <= RCON_INIT;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_ks_en   <= 1'b1;
            r_state   <= StWait;
          end
        end
        StWait: begin
          if (ks_flag_i) begin
            r_key      <= ks_key_i;
            r_rk_valid <= 1'b1;
            r_rk_idx   <= r_round;
            r_ks_en    <= 1'b0;
            if (w_last) begin
              // busy stays high through the done cycle and drops from IDLE.
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_round   <= r_round + 4'd1;
              r_rcon    <= aes_xtime(r_rcon);
              r_ks_rcon <= aes_xtime(r_rcon);
              r_state   <= StGap;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_ks_en <= 1'b0;
            r_state <= StErr;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        StGap: begin
          // One idle cycle lets KeySchedule restart before the next round.
          r_cnt   <= '0;
          r_ks_en <= 1'b1;
          r_state <= StWait;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign rk_valid = r_rk_valid;
  assign rk_idx   = r_rk_idx;
  assign ks_en    = r_ks_en;
  assign ks_rcon  = r_ks_rcon;
  assign ks_key_o = r_key;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed bench for aes_key_expand_ctrl with a behavioural KeySchedule stub.
module tb_aes_key_expand_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] cipher_key_i;
  logic         busy;
  logic         done;
  logic         err;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         ks_en;
  logic [7:0]   ks_rcon;
  logic [127:0] ks_key_o;
  logic         ks_flag_i;
  logic [127:0] ks_key_i;

  int n_total;
  int n_bad;

  aes_key_expand_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cipher_key_i(cipher_key_i),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rk_valid    (rk_valid),
    .rk_idx      (rk_idx),
    .rd_idx      (rd_idx),
    .rd_key      (rd_key),
    .ks_en       (ks_en),
    .ks_rcon     (ks_rcon),
    .ks_key_o    (ks_key_o),
    .ks_flag_i   (ks_flag_i),
    .ks_key_i    (ks_key_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS-197 byte 0 is the leftmost byte; the DUT puts byte 0 in bits [7:0].
  function automatic logic [127:0] brev(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] fips(input int i);
    logic [127:0] v;
    case (i)
      0:  v = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      1:  v = 128'ha0fafe1788542cb123a339392a6c7605;
      2:  v = 128'hf2c295f27a96b9435935807a7359f67f;
      3:  v = 128'h3d80477d4716fe3e1e237e446d7a883b;
      4:  v = 128'hef44a541a8525b7fb671253bdb0bad00;
      5:  v = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      6:  v = 128'h6d88a37a110b3efddbf98641ca0093fd;
      7:  v = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      8:  v = 128'head27321b58dbad2312bf5607f8d292f;
      9:  v = 128'hac7766f319fadc2128d12941575c006e;
      10: v = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      default: v = '0;
    endcase
    return brev(v);
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] t;
    case (r)
      1: t = 8'h01; 2: t = 8'h02; 3: t = 8'h04; 4: t = 8'h08; 5: t = 8'h10;
      6: t = 8'h20; 7: t = 8'h40; 8: t = 8'h80; 9: t = 8'h1b; 10: t = 8'h36;
      default: t = 8'h00;
    endcase
    return t;
  endfunction

  // Stub KeySchedule: known FIPS chain maps to the next FIPS key, anything else to a simple mix.
  function automatic logic [127:0] ks_model(input logic [127:0] k, input logic [7:0] rc);
    for (int r = 1; r <= 10; r++) begin
      if (k == fips(r - 1) && rc == rcon_of(r)) return fips(r);
    end
    return {k[119:0], k[127:120]} ^ {120'b0, rc};
  endfunction

  int stub_lat;
  bit stub_dead;
  int s_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_cnt <= 0;
    else        s_cnt <= ks_en ? s_cnt + 1 : 0;
  end

  always_comb begin
    ks_flag_i = ks_en && !stub_dead && (s_cnt == stub_lat);
    ks_key_i  = ks_model(ks_key_o, ks_rcon);
  end

  // Passive monitor, sampled on the falling edge.
  int         rk_n, done_n, rc_n, gap_bad, unstable, misalign, low_run;
  logic [3:0] rk_log [16];
  logic [7:0] rc_log [16];
  logic       prev_en;
  logic [127:0] prev_key;
  logic [7:0] prev_rc;

  always @(negedge clk) begin
    if (rk_valid) begin
      if (rk_n < 16) rk_log[rk_n] = rk_idx;
      rk_n++;
    end
    if (done) begin
      done_n++;
      if (!(rk_valid && rk_idx == 4'd10)) misalign++;
    end
    if (ks_en && !prev_en) begin
      if (rc_n < 16) rc_log[rc_n] = ks_rcon;
      if (rc_n > 0 && low_run != 1) gap_bad++;
      rc_n++;
    end
    if (ks_en && prev_en && (ks_key_o !== prev_key || ks_rcon !== prev_rc)) unstable++;
    low_run  = ks_en ? 0 : low_run + 1;
    prev_en  = ks_en;
    prev_key = ks_key_o;
    prev_rc  = ks_rcon;
  end

  task automatic clear_log();
    rk_n = 0; done_n = 0; rc_n = 0; gap_bad = 0; unstable = 0; misalign = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] k);
    start        = 1'b1;
    cipher_key_i = k;
    step();
    start        = 1'b0;
    cipher_key_i = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [145:0] outs;
    rst_n = 1'b0;
    repeat (2) step();
    outs = {busy, done, err, rk_valid, rk_idx, ks_en, ks_rcon, ks_key_o};
    n_total++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      n_total++;
      if (rd_key !== '0) begin
        n_bad++;
        $display("FAIL reset_store[%0d]: got %h want 0", i, rd_key);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fips();
    bit ok;
    stub_lat = 2;
    clear_log();
    pulse_start(fips(0));
    n_total++;
    if ({busy, ks_en, ks_rcon, ks_key_o} !== {1'b1, 1'b1, 8'h01, fips(0)}) begin
      n_bad++;
      $display("FAIL first_wait: busy=%b en=%b rcon=%h key=%h want 1 1 01 %h",
               busy, ks_en, ks_rcon, ks_key_o, fips(0));
    end
    wait_done(200, ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL fips_done_timeout: done=%b want 1", done);
    end
    step();
    n_total++;
    if (rk_n != 10 || done_n != 1 || misalign != 0) begin
      n_bad++;
      $display("FAIL fips_pulses: rk_valid=%0d done=%0d misalign=%0d want 10 1 0",
               rk_n, done_n, misalign);
    end
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (rk_log[i] !== 4'(i + 1) || rc_log[i] !== rcon_of(i + 1)) begin
        n_bad++;
        $display("FAIL fips_seq[%0d]: idx=%0d rcon=%h want %0d %h",
                 i, rk_log[i], rc_log[i], i + 1, rcon_of(i + 1));
      end
    end
    n_total++;
    if (rc_n != 10 || gap_bad != 0 || unstable != 0) begin
      n_bad++;
      $display("FAIL fips_en_shape: waits=%0d gap_bad=%0d unstable=%0d want 10 0 0",
               rc_n, gap_bad, unstable);
    end
    n_total++;
    if ({busy, done, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL fips_after: busy/done/err=%b want 000", {busy, done, err});
    end
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      #1;
      n_total++;
      if (rd_key !== fips(i)) begin
        n_bad++;
        $display("FAIL fips_rk[%0d]: got %h want %h", i, rd_key, fips(i));
      end
    end
  endtask

  task automatic test_oob_read();
    for (int i = 11; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      n_total++;
      if (rd_key !== '0) begin
        n_bad++;
        $display("FAIL oob_read[%0d]: got %h want 0", i, rd_key);
      end
    end
  endtask

  task automatic test_timeout();
    logic [127:0] k2;
    int en_cnt;
    bit seen;
    bit ok;
    k2 = 128'h00112233445566778899aabbccddeeff;
    stub_dead = 1'b1;
    en_cnt = 0;
    seen = 1'b0;
    pulse_start(k2);
    for (int i = 0; i < 400; i++) begin
      if (err) begin
        seen = 1'b1;
        break;
      end
      if (ks_en) en_cnt++;
      step();
    end
    n_total++;
    if (!seen || en_cnt != 255) begin
      n_bad++;
      $display("FAIL timeout_len: err_seen=%b wait_cycles=%0d want 1 255", seen, en_cnt);
    end
    repeat (5) step();
    rd_idx = 4'd0;
    #1;
    n_total++;
    if ({err, busy, ks_en, done} !== 4'b1000 || rd_key !== k2) begin
      n_bad++;
      $display("FAIL timeout_hold: err/busy/en/done=%b store0=%h want 1000 %h",
               {err, busy, ks_en, done}, rd_key, k2);
    end
    stub_dead = 1'b0;
    stub_lat  = 0;
    pulse_start(fips(0));
    n_total++;
    if ({err, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_restart: err/busy=%b want 01", {err, busy});
    end
    wait_done(200, ok);
    step();
    rd_idx = 4'd10;
    #1;
    n_total++;
    if (!ok || rd_key !== fips(10)) begin
      n_bad++;
      $display("FAIL timeout_recover: done=%b rk10=%h want 1 %h", ok, rd_key, fips(10));
    end
  endtask

  task automatic test_start_busy();
    bit seen;
    bit ok;
    stub_lat = 1;
    clear_log();
    pulse_start(fips(0));
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ks_en && ks_rcon == 8'h04) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    pulse_start(128'hdeadbeef_cafef00d_01234567_89abcdef);
    n_total++;
    if (!seen || {busy, ks_en, ks_rcon} !== {1'b1, 1'b1, 8'h04} || ks_key_o !== fips(2)) begin
      n_bad++;
      $display("FAIL busy_ignore: seen=%b busy=%b en=%b rcon=%h key=%h want 1 1 1 04 %h",
               seen, busy, ks_en, ks_rcon, ks_key_o, fips(2));
    end
    wait_done(200, ok);
    step();
    n_total++;
    if (!ok || rk_n != 10 || done_n != 1) begin
      n_bad++;
      $display("FAIL busy_run: done=%b rk_valid=%0d done_n=%0d want 1 10 1", ok, rk_n, done_n);
    end
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      #1;
      n_total++;
      if (rd_key !== fips(i)) begin
        n_bad++;
        $display("FAIL busy_rk[%0d]: got %h want %h", i, rd_key, fips(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [145:0] outs;
    bit seen;
    bit ok;
    stub_lat = 2;
    pulse_start(fips(0));
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ks_en && ks_rcon == 8'h10) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    outs = {busy, done, err, rk_valid, rk_idx, ks_en, ks_rcon, ks_key_o};
    n_total++;
    if (!seen || outs !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: seen=%b got %h want 0", seen, outs);
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      n_total++;
      if (rd_key !== '0) begin
        n_bad++;
        $display("FAIL midreset_store[%0d]: got %h want 0", i, rd_key);
      end
    end
    step();
    rst_n = 1'b1;
    step();
    clear_log();
    pulse_start(fips(0));
    wait_done(200, ok);
    step();
    n_total++;
    if (!ok || rk_n != 10 || done_n != 1) begin
      n_bad++;
      $display("FAIL midreset_run: done=%b rk_valid=%0d done_n=%0d want 1 10 1",
               ok, rk_n, done_n);
    end
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      #1;
      n_total++;
      if (rd_key !== fips(i)) begin
        n_bad++;
        $display("FAIL midreset_rk[%0d]: got %h want %h", i, rd_key, fips(i));
      end
    end
  endtask

  initial begin
    n_total      = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    cipher_key_i = '0;
    rd_idx       = '0;
    stub_lat     = 2;
    stub_dead    = 1'b0;
    prev_en      = 1'b0;
    prev_key     = '0;
    prev_rc      = '0;
    low_run      = 0;
    clear_log();
    test_reset();
    test_fips();
    test_oob_read();
    test_timeout();
    test_start_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
